// File: rtl/add_accumulator.sv
// Batch accumulator: sums N_OPS 4-bit operands through an external ripple adder,
// presents SUM/OVF with a valid/ready handshake, then clears for the next batch.
module add_accumulator #(
  parameter int N_OPS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic [3:0] ADD_X,
  output logic [3:0] ADD_Y,
  input  logic [3:0] ADD_S,
  input  logic       ADD_CO,
  output logic [3:0] SUM,
  output logic       OVF,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       BUSY
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(N_OPS - 1);

  state_t     state, state_next;
  logic [3:0] acc;
  logic [3:0] cnt;
  logic       ovf;
  logic       accept;
  logic       last;
  logic       release_res;

  always_comb begin
    DIN_READY   = (state != DONE);
    accept      = DIN_VALID & DIN_READY;
    last        = (cnt == LAST_CNT);
    release_res = (state == DONE) & OUT_READY;
    state_next  = state;
    unique case (state)
      IDLE: if (accept) state_next = last ? DONE : ACC;
      ACC:  if (accept && last) state_next = DONE;
      DONE: if (OUT_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The adder operand is forced to zero while a result is held, so ADD_S
  // never reflects a stray DIN during backpressure.
  always_comb begin
    ADD_X     = acc;
    ADD_Y     = (state == DONE) ? '0 : DIN;
    SUM       = acc;
    OVF       = ovf;
    OUT_VALID = (state == DONE);
    BUSY      = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (release_res) begin
        acc <= '0;
        ovf <= 1'b0;
        cnt <= '0;
      end else if (accept) begin
        acc <= ADD_S;
        ovf <= ovf | ADD_CO;
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_add_accumulator.sv
// Self-checking bench for add_accumulator: N_OPS=4 and N_OPS=1 instances,
// each wired to a behavioural 4-bit adder, checked against a running-total model.
module tb_add_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] add_x, add_y, add_s;
  logic       add_co;
  logic [3:0] sum;
  logic       ovf;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  logic [3:0] s_din;
  logic       s_din_valid;
  logic       s_din_ready;
  logic [3:0] s_add_x, s_add_y, s_add_s;
  logic       s_add_co;
  logic [3:0] s_sum;
  logic       s_ovf;
  logic       s_out_valid;
  logic       s_out_ready;
  logic       s_busy;

  assign {add_co, add_s}     = 5'(add_x) + 5'(add_y);
  assign {s_add_co, s_add_s} = 5'(s_add_x) + 5'(s_add_y);

  add_accumulator #(.N_OPS(4)) u_dut (
    .CLK(clk), .RST(rst), .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
    .ADD_X(add_x), .ADD_Y(add_y), .ADD_S(add_s), .ADD_CO(add_co),
    .SUM(sum), .OVF(ovf), .OUT_VALID(out_valid), .OUT_READY(out_ready), .BUSY(busy)
  );

  add_accumulator #(.N_OPS(1)) u_dut1 (
    .CLK(clk), .RST(rst), .DIN(s_din), .DIN_VALID(s_din_valid), .DIN_READY(s_din_ready),
    .ADD_X(s_add_x), .ADD_Y(s_add_y), .ADD_S(s_add_s), .ADD_CO(s_add_co),
    .SUM(s_sum), .OVF(s_ovf), .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready), .BUSY(s_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] ops  [4];
  int         gaps [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Model: the batch result is the plain integer total; SUM is that total
  // mod 16 and OVF is set iff the total ever reached 16.
  task automatic run_batch(input int hold);
    int total = 0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        din_valid = 1'b0;
        din       = 4'($urandom);
        out_ready = 1'b1;
        #1;
        check("gap_out_valid", 32'(out_valid), 32'd0);
        check("gap_acc", 32'(add_x), 32'(total % 16));
        check("gap_busy", 32'(busy), 32'(i > 0));
        step;
      end
      din_valid = 1'b1;
      din       = ops[i];
      out_ready = (hold == 0);
      #1;
      check("acc_add_x", 32'(add_x), 32'(total % 16));
      check("acc_add_y", 32'(add_y), 32'(ops[i]));
      check("acc_din_ready", 32'(din_ready), 32'd1);
      check("acc_busy", 32'(busy), 32'(i > 0));
      check("acc_out_valid", 32'(out_valid), 32'd0);
      step;
      total += int'(ops[i]);
    end
    din_valid = 1'b1;
    din       = 4'h5;
    #1;
    check("res_out_valid", 32'(out_valid), 32'd1);
    check("res_sum", 32'(sum), 32'(total % 16));
    check("res_ovf", 32'(ovf), 32'(total >= 16));
    check("res_busy", 32'(busy), 32'd1);
    check("res_din_ready", 32'(din_ready), 32'd0);
    check("res_add_y", 32'(add_y), 32'd0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      step;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(total % 16));
      check("hold_ovf", 32'(ovf), 32'(total >= 16));
      check("hold_din_ready", 32'(din_ready), 32'd0);
    end
    out_ready = 1'b1;
    step;
    check("rel_out_valid", 32'(out_valid), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);
    check("rel_sum", 32'(sum), 32'd0);
    check("rel_ovf", 32'(ovf), 32'd0);
    din_valid = 1'b0;
  endtask

  task automatic set_batch(input logic [15:0] v, input logic [15:0] g);
    for (int i = 0; i < 4; i++) begin
      ops[i]  = v[15-4*i -: 4];
      gaps[i] = int'(g[15-4*i -: 4]);
    end
  endtask

  initial begin
    rst = 1'b1;
    din = '0; din_valid = 1'b0; out_ready = 1'b1;
    s_din = '0; s_din_valid = 1'b0; s_out_ready = 1'b1;
    step;
    step;
    check("rst_din_ready", 32'(din_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_x", 32'(add_x), 32'd0);
    rst = 1'b0;

    set_batch(16'hB27A, 16'h0000); run_batch(0);
    set_batch(16'h4312, 16'h0000); run_batch(0);
    set_batch(16'h4312, 16'h0000); run_batch(3);
    set_batch(16'h1234, 16'h0201); run_batch(0);

    // Reset abandons a partial batch, taking priority over a same-cycle accept.
    din_valid = 1'b1; din = 4'hF; step; step;
    rst = 1'b1; din = 4'h7; step;
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_add_x", 32'(add_x), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; din_valid = 1'b0;
    set_batch(16'h1111, 16'h0000); run_batch(0);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++) begin
        ops[i]  = 4'($urandom);
        gaps[i] = ($urandom_range(0, 99) < 30) ? int'($urandom_range(1, 3)) : 0;
      end
      run_batch(int'($urandom_range(0, 3)));
    end

    for (int k = 0; k < 8; k++) begin
      logic [3:0] v;
      v = (k == 0) ? 4'hD : 4'($urandom);
      check("n1_busy", 32'(s_busy), 32'd0);
      check("n1_add_x", 32'(s_add_x), 32'd0);
      s_din_valid = 1'b1; s_din = v; s_out_ready = 1'b1;
      step;
      s_din_valid = 1'b0;
      check("n1_out_valid", 32'(s_out_valid), 32'd1);
      check("n1_sum", 32'(s_sum), 32'(v));
      check("n1_ovf", 32'(s_ovf), 32'd0);
      step;
      check("n1_release", 32'(s_out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 SHALL have parameter N_OPS, default 4, the number of operands summed per batch (legal range 1..15).
REQ-002 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 SHALL have port DIN  input  4  operand stream data.
REQ-005 SHALL have port DIN_VALID  input  1  DIN holds a valid operand.
REQ-006 SHALL have port DIN_READY  output  1  block accepts an operand this cycle.
REQ-007 SHALL have port ADD_X  output  4  drives X of the external 4-bit ripple adder.
REQ-008 SHALL have port ADD_Y  output  4  drives Y of the external adder.
REQ-009 SHALL have port ADD_S  input  4  S returned from the external adder.
REQ-010 SHALL have port ADD_CO  input  1  CO returned from the external adder.
REQ-011 SHALL have port SUM  output  4  batch result, modulo 16.
REQ-012 SHALL have port OVF  output  1  sticky carry-out flag for the batch.
REQ-013 SHALL have port OUT_VALID  output  1  SUM/OVF hold a valid result.
REQ-014 SHALL have port OUT_READY  input  1  consumer takes the result.
REQ-015 SHALL have port BUSY  output  1  batch in progress or result pending.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, ACC, DONE.
REQ-017 SHALL hold internal registers acc[3:0], ovf, and cnt[3:0].
REQ-018 SHALL drive ADD_X = acc and ADD_Y = DIN combinationally in IDLE and ACC; in DONE it SHALL drive ADD_Y = 0.
REQ-019 SHALL assert DIN_READY = 1 in IDLE and ACC, and DIN_READY = 0 in DONE.
REQ-020 SHALL define an accept as DIN_VALID & DIN_READY on a rising edge; on accept: acc <= ADD_S, ovf <= ovf | ADD_CO, cnt <= cnt + 1.
REQ-021 SHALL move IDLE -> ACC on the first accept when N_OPS > 1.
REQ-022 SHALL move IDLE/ACC -> DONE on the accept that makes cnt equal N_OPS; with N_OPS = 1, IDLE -> DONE directly.
REQ-023 SHALL leave all state unchanged on cycles without an accept (DIN_VALID gaps).
REQ-024 SHALL present the result one cycle after the last accept: OUT_VALID = 1 in DONE only, with SUM = acc and OVF = ovf.
REQ-025 SHALL hold SUM and OVF stable while OUT_VALID = 1 and OUT_READY = 0.
REQ-026 SHALL, in DONE when OUT_READY = 1, move to IDLE and clear acc, ovf, and cnt to 0.
REQ-027 SHALL NOT accept an operand in that same release cycle, since DIN_READY = 0.
REQ-028 SHALL wrap the sum modulo 16; any carry SHALL set ovf, which stays set until the batch is released or reset.
REQ-029 SHALL assert BUSY = 1 whenever the state is not IDLE.

Reset
REQ-030 SHALL, while RST = 1 at a rising edge, set state = IDLE, acc = 0, ovf = 0, cnt = 0.
REQ-031 SHALL give the following output values in reset: DIN_READY = 1, OUT_VALID = 0, SUM = 0, OVF = 0, BUSY = 0, ADD_X = 0.
REQ-032 SHALL give RST priority over accept and release in the same cycle.
REQ-033 SHALL discard a partial batch or a pending result on reset, without emitting it.

Verification
REQ-034 SHALL verify a basic batch with carry: N_OPS = 4; DIN 0xB, 0x2, 0x7, 0xA on consecutive cycles with OUT_READY = 1 -> the cycle after the 4th accept shows OUT_VALID = 1, SUM = 0xE, OVF = 1, BUSY = 1; the next cycle shows IDLE.
REQ-035 SHALL verify a batch without carry: DIN 0x4, 0x3, 0x1, 0x2 -> SUM = 0xA, OVF = 0.
REQ-036 SHALL verify backpressure: after a batch completes, hold OUT_READY = 0 for 3 cycles with DIN_VALID = 1, DIN = 0x5 -> SUM/OVF unchanged, DIN_READY = 0, no accept; raising OUT_READY returns to IDLE, and the next batch starts from acc = 0.
REQ-037 SHALL verify valid gaps: operands 0x1, gap, gap, 0x2, 0x3, gap, 0x4 -> SUM = 0xA, with result 1 cycle after 0x4 is accepted.
REQ-038 SHALL verify reset mid-batch: accept 0xF, 0xF, assert RST 1 cycle -> acc = 0, OVF = 0, BUSY = 0; then 0x1, 0x1, 0x1, 0x1 -> SUM = 0x4, OVF = 0.
REQ-039 SHALL verify N_OPS = 1: DIN 0xD accepted -> the next cycle shows OUT_VALID = 1, SUM = 0xD, OVF = 0.
